// File: rtl/vc_switch_allocator_if.sv
// vc_switch_allocator_if
// Bundle between the per-port VC input buffers / route computation
// (master side) and the switch allocator (slave side).
//   req_valid, req_dest, relieve      : requester -> allocator
//   grant, reserved                   : per-requester status back to buffers
//   output_busy, route_select_port/vc : per-output crossbar control
//   input_locked                      : per-input-port ownership flag
//   err_bad_dest                      : sticky out-of-range destination flag
interface vc_switch_allocator_if #(
    parameter int INPUTS  = 5,
    parameter int OUTPUTS = 5,
    parameter int VC      = 2
);
    localparam int NREQ       = INPUTS * VC;
    localparam int DEST_WIDTH = (OUTPUTS > 1) ? $clog2(OUTPUTS) : 1;
    localparam int PORT_WIDTH = (INPUTS > 1) ? $clog2(INPUTS) : 1;
    localparam int VC_WIDTH   = (VC > 1) ? $clog2(VC) : 1;

    logic [NREQ-1:0]                     req_valid;
    logic [NREQ-1:0][DEST_WIDTH-1:0]     req_dest;
    logic [NREQ-1:0]                     relieve;
    logic [NREQ-1:0]                     grant;
    logic [NREQ-1:0]                     reserved;
    logic [OUTPUTS-1:0]                  output_busy;
    logic [OUTPUTS-1:0][PORT_WIDTH-1:0]  route_select_port;
    logic [OUTPUTS-1:0][VC_WIDTH-1:0]    route_select_vc;
    logic [INPUTS-1:0]                   input_locked;
    logic                                err_bad_dest;

    modport master (
        output req_valid, req_dest, relieve,
        input  grant, reserved, output_busy, route_select_port,
               route_select_vc, input_locked, err_bad_dest
    );

    modport slave (
        input  req_valid, req_dest, relieve,
        output grant, reserved, output_busy, route_select_port,
               route_select_vc, input_locked, err_bad_dest
    );
endinterface

// File: rtl/vc_switch_allocator.sv
// vc_switch_allocator
// Switch allocator for the mesh NoC router. Every (input port, VC) pair is a
// requester r = port*VC + vc with its own IDLE/WAIT/GRANT/HOLD state machine.
// Waiting requesters are arbitrated per output with a round-robin pointer;
// a granted path is held (output busy, input port locked) until the
// requester's tail flit relieves it.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset, drops every path
//   bus  - vc_switch_allocator_if.slave: requests in, grants, path status
//          and crossbar select lines out
module vc_switch_allocator #(
    parameter int INPUTS  = 5,
    parameter int OUTPUTS = 5,
    parameter int VC      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    vc_switch_allocator_if.slave  bus
);
    localparam int NREQ       = INPUTS * VC;
    localparam int DEST_WIDTH = (OUTPUTS > 1) ? $clog2(OUTPUTS) : 1;
    localparam int PORT_WIDTH = (INPUTS > 1) ? $clog2(INPUTS) : 1;
    localparam int VC_WIDTH   = (VC > 1) ? $clog2(VC) : 1;
    localparam int REQ_WIDTH  = (NREQ > 1) ? $clog2(NREQ) : 1;

    // One extra bit so destinations that do not fit OUTPUTS compare correctly.
    localparam logic [DEST_WIDTH:0] DEST_LIMIT = (DEST_WIDTH + 1)'(OUTPUTS);

    typedef enum logic [1:0] {IDLE, WAIT, GRANT, HOLD} state_t;

    state_t                             state   [NREQ];
    logic [DEST_WIDTH-1:0]              dest_q  [NREQ];
    logic [REQ_WIDTH-1:0]               rr_ptr  [OUTPUTS];
    logic [NREQ-1:0]                    grant_q;
    logic [NREQ-1:0]                    reserved_q;
    logic [OUTPUTS-1:0]                 busy_q;
    logic [INPUTS-1:0]                  locked_q;
    logic                               err_q;
    logic [OUTPUTS-1:0][PORT_WIDTH-1:0] sel_port_q;
    logic [OUTPUTS-1:0][VC_WIDTH-1:0]   sel_vc_q;

    // Arbitration results
    logic [NREQ-1:0]                    win_req;
    logic [OUTPUTS-1:0]                 win_out;
    logic [OUTPUTS-1:0][REQ_WIDTH-1:0]  win_idx;
    logic [OUTPUTS-1:0][PORT_WIDTH-1:0] win_port;
    logic [OUTPUTS-1:0][VC_WIDTH-1:0]   win_vc;

    // Per-output scratch used while walking the outputs
    logic [NREQ-1:0]                    cand;
    logic [NREQ-1:0]                    hi_oh;
    logic [NREQ-1:0]                    lo_oh;
    logic [NREQ-1:0]                    pick_oh;
    logic                               found_hi;
    logic                               found_lo;
    logic                               conflict;
    logic                               still_valid;
    logic [REQ_WIDTH-1:0]               pick_idx;
    logic [PORT_WIDTH-1:0]              pick_port;
    logic [VC_WIDTH-1:0]                pick_vc;
    logic [INPUTS-1:0]                  port_claim;

    // Outputs are walked in ascending order so a lower output claims an input
    // port first; a higher output that picked a VC of an already claimed port
    // grants nobody this cycle. A pick whose requester withdraws this cycle
    // still claims its port but is not a win: the output stays free and the
    // pointer holds.
    always_comb begin
        win_req     = '0;
        win_out     = '0;
        win_idx     = '0;
        win_port    = '0;
        win_vc      = '0;
        port_claim  = '0;
        cand        = '0;
        hi_oh       = '0;
        lo_oh       = '0;
        pick_oh     = '0;
        found_hi    = 1'b0;
        found_lo    = 1'b0;
        conflict    = 1'b0;
        still_valid = 1'b0;
        pick_idx    = '0;
        pick_port   = '0;
        pick_vc     = '0;
        for (int o = 0; o < OUTPUTS; o++) begin
            hi_oh       = '0;
            lo_oh       = '0;
            found_hi    = 1'b0;
            found_lo    = 1'b0;
            conflict    = 1'b0;
            still_valid = 1'b0;
            pick_idx    = '0;
            pick_port   = '0;
            pick_vc     = '0;
            for (int r = 0; r < NREQ; r++) begin
                cand[r] = (state[r] == WAIT) && (dest_q[r] == DEST_WIDTH'(o))
                          && !busy_q[o] && !locked_q[r / VC];
            end
            // First candidate at/after the pointer, else the first one overall
            // (the cyclic wrap).
            for (int r = 0; r < NREQ; r++) begin
                if (cand[r]) begin
                    if (!found_lo) begin
                        lo_oh[r] = 1'b1;
                        found_lo = 1'b1;
                    end
                    if (!found_hi && (REQ_WIDTH'(r) >= rr_ptr[o])) begin
                        hi_oh[r] = 1'b1;
                        found_hi = 1'b1;
                    end
                end
            end
            pick_oh = found_hi ? hi_oh : lo_oh;
            for (int r = 0; r < NREQ; r++) begin
                if (pick_oh[r]) begin
                    conflict    = conflict | port_claim[r / VC];
                    still_valid = still_valid | bus.req_valid[r];
                    pick_idx    = REQ_WIDTH'(r);
                    pick_port   = PORT_WIDTH'(r / VC);
                    pick_vc     = VC_WIDTH'(r % VC);
                end
            end
            if (found_lo && !conflict) begin
                for (int r = 0; r < NREQ; r++) begin
                    if (pick_oh[r]) begin
                        port_claim[r / VC] = 1'b1;
                    end
                end
                if (still_valid) begin
                    win_out[o]  = 1'b1;
                    win_idx[o]  = pick_idx;
                    win_port[o] = pick_port;
                    win_vc[o]   = pick_vc;
                    win_req     = win_req | pick_oh;
                end
            end
        end
    end

    // Requester state machines plus the per-output ownership registers.
    // A win and a release can never touch the same output or port at one
    // edge (a busy output / locked port is not arbitrable), so the order of
    // the updates below does not matter.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREQ; r++) begin
                state[r]  <= IDLE;
                dest_q[r] <= '0;
            end
            for (int o = 0; o < OUTPUTS; o++) begin
                rr_ptr[o] <= '0;
            end
            grant_q    <= '0;
            reserved_q <= '0;
            busy_q     <= '0;
            locked_q   <= '0;
            err_q      <= 1'b0;
            sel_port_q <= '0;
            sel_vc_q   <= '0;
        end else begin
            grant_q <= '0;
            for (int r = 0; r < NREQ; r++) begin
                case (state[r])
                    IDLE: begin
                        if (bus.req_valid[r]) begin
                            if ({1'b0, bus.req_dest[r]} < DEST_LIMIT) begin
                                dest_q[r] <= bus.req_dest[r];
                                state[r]  <= WAIT;
                            end else begin
                                err_q <= 1'b1;
                            end
                        end
                    end
                    WAIT: begin
                        if (!bus.req_valid[r]) begin
                            state[r] <= IDLE;
                        end else if (win_req[r]) begin
                            state[r]         <= GRANT;
                            grant_q[r]       <= 1'b1;
                            locked_q[r / VC] <= 1'b1;
                        end
                    end
                    GRANT: begin
                        state[r]      <= HOLD;
                        reserved_q[r] <= 1'b1;
                    end
                    HOLD: begin
                        if (bus.relieve[r]) begin
                            state[r]         <= IDLE;
                            reserved_q[r]    <= 1'b0;
                            locked_q[r / VC] <= 1'b0;
                            for (int o = 0; o < OUTPUTS; o++) begin
                                if (dest_q[r] == DEST_WIDTH'(o)) begin
                                    busy_q[o] <= 1'b0;
                                end
                            end
                        end
                    end
                    default: state[r] <= IDLE;
                endcase
            end
            for (int o = 0; o < OUTPUTS; o++) begin
                if (win_out[o]) begin
                    busy_q[o]     <= 1'b1;
                    sel_port_q[o] <= win_port[o];
                    sel_vc_q[o]   <= win_vc[o];
                    rr_ptr[o]     <= (win_idx[o] == REQ_WIDTH'(NREQ - 1)) ?
                                     '0 : win_idx[o] + 1'b1;
                end
            end
        end
    end

    assign bus.grant             = grant_q;
    assign bus.reserved          = reserved_q;
    assign bus.output_busy       = busy_q;
    assign bus.route_select_port = sel_port_q;
    assign bus.route_select_vc   = sel_vc_q;
    assign bus.input_locked      = locked_q;
    assign bus.err_bad_dest      = err_q;
endmodule

// File: tb/tb_vc_switch_allocator.sv
// tb_vc_switch_allocator
// Self-checking bench for vc_switch_allocator (5 inputs, 5 outputs, 2 VCs).
// Each scenario task drives requests/relieves on a fixed cycle schedule,
// pushes the grant pulses it expects (requester, cycle) onto a scoreboard
// queue and checks path status levels inline. A monitor pops the queue on
// every observed grant pulse.
module tb_vc_switch_allocator;
    localparam int INPUTS  = 5;
    localparam int OUTPUTS = 5;
    localparam int VC      = 2;
    localparam int NREQ    = INPUTS * VC;

    typedef struct {
        int req;
        int cyc;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc = 0;
    int   compared = 0;
    int   mismatched = 0;
    exp_t exp_q[$];

    vc_switch_allocator_if #(.INPUTS(INPUTS), .OUTPUTS(OUTPUTS), .VC(VC)) bus ();

    vc_switch_allocator #(.INPUTS(INPUTS), .OUTPUTS(OUTPUTS), .VC(VC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle number = count of rising edges so far.
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: every grant pulse must match the head expectation.
    always @(posedge clk) begin
        #1;
        for (int r = 0; r < NREQ; r++) begin
            if (bus.grant[r] === 1'b1) begin
                compared++;
                if (exp_q.size() == 0) begin
                    mismatched++;
                    $display("[TB] FAIL grant_unexpected: got grant r=%0d at cycle %0d, required none", r, cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (e.req !== r || e.cyc !== cyc) begin
                        mismatched++;
                        $display("[TB] FAIL grant_order: got r=%0d at cycle %0d, required r=%0d at cycle %0d", r, cyc, e.req, e.cyc);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_grant(input int r, input int at);
        exp_t e;
        e.req = r;
        e.cyc = at;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_dest  = '0;
        bus.relieve   = '0;
        tick();
        tick();
        compared++;
        if (bus.grant !== '0) begin mismatched++; $display("[TB] FAIL reset_grant: got %b required 0", bus.grant); end
        compared++;
        if (bus.reserved !== '0) begin mismatched++; $display("[TB] FAIL reset_reserved: got %b required 0", bus.reserved); end
        compared++;
        if (bus.output_busy !== '0) begin mismatched++; $display("[TB] FAIL reset_busy: got %b required 0", bus.output_busy); end
        compared++;
        if (bus.input_locked !== '0) begin mismatched++; $display("[TB] FAIL reset_locked: got %b required 0", bus.input_locked); end
        compared++;
        if (bus.err_bad_dest !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_err: got %b required 0", bus.err_bad_dest); end
        compared++;
        if (bus.route_select_port !== '0) begin mismatched++; $display("[TB] FAIL reset_sel_port: got %h required 0", bus.route_select_port); end
        compared++;
        if (bus.route_select_vc !== '0) begin mismatched++; $display("[TB] FAIL reset_sel_vc: got %b required 0", bus.route_select_vc); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_path();
        int c;
        c = cyc;
        bus.req_valid[2] = 1'b1;
        bus.req_dest[2]  = 3'd3;
        expect_grant(2, c + 2);
        tick();
        compared++;
        if (bus.output_busy !== 5'b00000) begin mismatched++; $display("[TB] FAIL single_busy_wait: got %b required 00000", bus.output_busy); end
        tick();
        bus.req_valid[2] = 1'b0;
        compared++;
        if (bus.output_busy !== 5'b01000) begin mismatched++; $display("[TB] FAIL single_busy: got %b required 01000", bus.output_busy); end
        compared++;
        if (bus.route_select_port[3] !== 3'd1) begin mismatched++; $display("[TB] FAIL single_sel_port: got %0d required 1", bus.route_select_port[3]); end
        compared++;
        if (bus.route_select_vc[3] !== 1'b0) begin mismatched++; $display("[TB] FAIL single_sel_vc: got %0d required 0", bus.route_select_vc[3]); end
        compared++;
        if (bus.input_locked !== 5'b00010) begin mismatched++; $display("[TB] FAIL single_locked: got %b required 00010", bus.input_locked); end
        compared++;
        if (bus.reserved !== '0) begin mismatched++; $display("[TB] FAIL single_reserved_grant: got %b required 0", bus.reserved); end
        tick();
        compared++;
        if (bus.reserved !== 10'b0000000100) begin mismatched++; $display("[TB] FAIL single_reserved_hold: got %b required 0000000100", bus.reserved); end
        tick();
        tick();
        compared++;
        if (bus.output_busy !== 5'b01000) begin mismatched++; $display("[TB] FAIL single_busy_hold: got %b required 01000", bus.output_busy); end
        bus.relieve[2] = 1'b1;
        tick();
        bus.relieve[2] = 1'b0;
        compared++;
        if (bus.output_busy !== 5'b00000) begin mismatched++; $display("[TB] FAIL single_busy_release: got %b required 00000", bus.output_busy); end
        compared++;
        if (bus.input_locked !== 5'b00000) begin mismatched++; $display("[TB] FAIL single_locked_release: got %b required 00000", bus.input_locked); end
        compared++;
        if (bus.reserved !== '0) begin mismatched++; $display("[TB] FAIL single_reserved_release: got %b required 0", bus.reserved); end
        compared++;
        if (bus.route_select_port[3] !== 3'd1) begin mismatched++; $display("[TB] FAIL single_sel_keep: got %0d required 1", bus.route_select_port[3]); end
        tick();
        compared++;
        if (exp_q.size() != 0) begin mismatched++; $display("[TB] FAIL single_pending: got %0d grants outstanding, required 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_round_robin();
        int c;
        c = cyc;
        bus.req_valid[0] = 1'b1; bus.req_dest[0] = 3'd0;
        bus.req_valid[4] = 1'b1; bus.req_dest[4] = 3'd0;
        bus.req_valid[8] = 1'b1; bus.req_dest[8] = 3'd0;
        expect_grant(0, c + 2);
        expect_grant(4, c + 6);
        expect_grant(8, c + 10);
        expect_grant(0, c + 14);
        for (int k = 1; k <= 19; k++) begin
            tick();
            case (k)
                2:  bus.req_valid[0] = 1'b0;
                4:  bus.relieve[0] = 1'b1;
                5:  bus.relieve[0] = 1'b0;
                6:  begin bus.req_valid[4] = 1'b0; bus.req_valid[0] = 1'b1; end
                8:  bus.relieve[4] = 1'b1;
                9:  bus.relieve[4] = 1'b0;
                10: bus.req_valid[8] = 1'b0;
                12: bus.relieve[8] = 1'b1;
                13: bus.relieve[8] = 1'b0;
                14: bus.req_valid[0] = 1'b0;
                16: bus.relieve[0] = 1'b1;
                17: bus.relieve[0] = 1'b0;
                default: ;
            endcase
            if (k == 6 || k == 10) begin
                compared++;
                if (bus.route_select_port[0] !== 3'((k - 2) / 2)) begin mismatched++; $display("[TB] FAIL rr_sel_port k=%0d: got %0d required %0d", k, bus.route_select_port[0], (k - 2) / 2); end
            end
            if (k == 14) begin
                compared++;
                if (bus.route_select_port[0] !== 3'd0) begin mismatched++; $display("[TB] FAIL rr_wrap_sel_port: got %0d required 0", bus.route_select_port[0]); end
            end
        end
        compared++;
        if (bus.output_busy !== 5'b00000) begin mismatched++; $display("[TB] FAIL rr_busy_end: got %b required 00000", bus.output_busy); end
        compared++;
        if (exp_q.size() != 0) begin mismatched++; $display("[TB] FAIL rr_pending: got %0d grants outstanding, required 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_input_lock();
        int c;
        c = cyc;
        bus.req_valid[0] = 1'b1; bus.req_dest[0] = 3'd1;
        expect_grant(0, c + 2);
        expect_grant(1, c + 8);
        for (int k = 1; k <= 13; k++) begin
            tick();
            case (k)
                2:  begin bus.req_valid[0] = 1'b0; bus.req_valid[1] = 1'b1; bus.req_dest[1] = 3'd2; end
                3:  bus.relieve[1] = 1'b1;
                4:  bus.relieve[1] = 1'b0;
                6:  bus.relieve[0] = 1'b1;
                7:  bus.relieve[0] = 1'b0;
                8:  bus.req_valid[1] = 1'b0;
                10: bus.relieve[1] = 1'b1;
                11: bus.relieve[1] = 1'b0;
                default: ;
            endcase
            if (k == 5) begin
                compared++;
                if (bus.input_locked !== 5'b00001) begin mismatched++; $display("[TB] FAIL lock_held: got %b required 00001", bus.input_locked); end
                compared++;
                if (bus.output_busy !== 5'b00010) begin mismatched++; $display("[TB] FAIL lock_busy_held: got %b required 00010", bus.output_busy); end
            end
            if (k == 7) begin
                compared++;
                if (bus.input_locked !== 5'b00000) begin mismatched++; $display("[TB] FAIL lock_cleared: got %b required 00000", bus.input_locked); end
            end
            if (k == 8) begin
                compared++;
                if (bus.output_busy !== 5'b00100) begin mismatched++; $display("[TB] FAIL lock_busy_new: got %b required 00100", bus.output_busy); end
                compared++;
                if (bus.route_select_vc[2] !== 1'b1) begin mismatched++; $display("[TB] FAIL lock_sel_vc: got %0d required 1", bus.route_select_vc[2]); end
                compared++;
                if (bus.route_select_port[2] !== 3'd0) begin mismatched++; $display("[TB] FAIL lock_sel_port: got %0d required 0", bus.route_select_port[2]); end
            end
        end
        compared++;
        if (exp_q.size() != 0) begin mismatched++; $display("[TB] FAIL lock_pending: got %0d grants outstanding, required 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_same_port();
        int c;
        c = cyc;
        bus.req_valid[2] = 1'b1; bus.req_dest[2] = 3'd0;
        bus.req_valid[3] = 1'b1; bus.req_dest[3] = 3'd4;
        expect_grant(2, c + 2);
        expect_grant(3, c + 6);
        for (int k = 1; k <= 11; k++) begin
            tick();
            if (k == 2 || k == 3) begin
                compared++;
                if (bus.output_busy !== 5'b00001) begin mismatched++; $display("[TB] FAIL same_port_busy k=%0d: got %b required 00001", k, bus.output_busy); end
            end
            if (k == 6) begin
                compared++;
                if (bus.output_busy !== 5'b10000) begin mismatched++; $display("[TB] FAIL same_port_busy_late: got %b required 10000", bus.output_busy); end
                compared++;
                if (bus.route_select_port[4] !== 3'd1 || bus.route_select_vc[4] !== 1'b1) begin mismatched++; $display("[TB] FAIL same_port_sel: got port %0d vc %0d required port 1 vc 1", bus.route_select_port[4], bus.route_select_vc[4]); end
            end
            case (k)
                2: bus.req_valid[2] = 1'b0;
                4: bus.relieve[2] = 1'b1;
                5: bus.relieve[2] = 1'b0;
                6: bus.req_valid[3] = 1'b0;
                8: bus.relieve[3] = 1'b1;
                9: bus.relieve[3] = 1'b0;
                default: ;
            endcase
        end
        compared++;
        if (exp_q.size() != 0) begin mismatched++; $display("[TB] FAIL same_port_pending: got %0d grants outstanding, required 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_bad_dest();
        bus.req_valid[5] = 1'b1;
        bus.req_dest[5]  = 3'd7;
        tick();
        compared++;
        if (bus.err_bad_dest !== 1'b1) begin mismatched++; $display("[TB] FAIL bad_dest_err: got %b required 1", bus.err_bad_dest); end
        tick();
        bus.req_valid[5] = 1'b0;
        compared++;
        if (bus.input_locked !== 5'b00000 || bus.output_busy !== 5'b00000) begin mismatched++; $display("[TB] FAIL bad_dest_no_path: got locked %b busy %b required 00000 00000", bus.input_locked, bus.output_busy); end
        tick();
        tick();
        compared++;
        if (bus.err_bad_dest !== 1'b1) begin mismatched++; $display("[TB] FAIL bad_dest_sticky: got %b required 1", bus.err_bad_dest); end
    endtask

    task automatic test_reset_mid_hold();
        int c;
        c = cyc;
        bus.req_valid[0] = 1'b1; bus.req_dest[0] = 3'd0;
        bus.req_valid[2] = 1'b1; bus.req_dest[2] = 3'd1;
        bus.req_valid[4] = 1'b1; bus.req_dest[4] = 3'd2;
        expect_grant(0, c + 2);
        expect_grant(2, c + 2);
        expect_grant(4, c + 2);
        expect_grant(6, c + 7);
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k == 2) begin
                bus.req_valid[0] = 1'b0; bus.req_valid[2] = 1'b0; bus.req_valid[4] = 1'b0;
            end
            if (k == 4) begin
                compared++;
                if (bus.reserved !== 10'b0000010101) begin mismatched++; $display("[TB] FAIL rst_mid_reserved: got %b required 0000010101", bus.reserved); end
                compared++;
                if (bus.output_busy !== 5'b00111) begin mismatched++; $display("[TB] FAIL rst_mid_busy: got %b required 00111", bus.output_busy); end
                rst = 1'b1;
            end
            if (k == 5) begin
                rst = 1'b0;
                compared++;
                if (bus.reserved !== '0 || bus.output_busy !== '0 || bus.input_locked !== '0) begin mismatched++; $display("[TB] FAIL rst_mid_clear: got reserved %b busy %b locked %b required all 0", bus.reserved, bus.output_busy, bus.input_locked); end
                compared++;
                if (bus.route_select_port !== '0 || bus.route_select_vc !== '0) begin mismatched++; $display("[TB] FAIL rst_mid_sel: got port %h vc %b required 0", bus.route_select_port, bus.route_select_vc); end
                compared++;
                if (bus.err_bad_dest !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_mid_err: got %b required 0", bus.err_bad_dest); end
                bus.req_valid[6] = 1'b1; bus.req_dest[6] = 3'd3;
            end
            if (k == 7) begin
                bus.req_valid[6] = 1'b0;
                compared++;
                if (bus.output_busy !== 5'b01000 || bus.route_select_port[3] !== 3'd3) begin mismatched++; $display("[TB] FAIL rst_mid_new_path: got busy %b port %0d required 01000 3", bus.output_busy, bus.route_select_port[3]); end
            end
            if (k == 9)  bus.relieve[6] = 1'b1;
            if (k == 10) bus.relieve[6] = 1'b0;
        end
        compared++;
        if (exp_q.size() != 0) begin mismatched++; $display("[TB] FAIL rst_mid_pending: got %0d grants outstanding, required 0", exp_q.size()); exp_q.delete(); end
    endtask

    initial begin
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_dest  = '0;
        bus.relieve   = '0;
        $display("[TB] starting vc_switch_allocator bench");
        test_reset();
        test_single_path();
        test_round_robin();
        test_input_lock();
        test_same_port();
        test_bad_dest();
        test_reset_mid_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
